// File: rtl/apb_mem_slave_ws.sv
// APB word-addressed RAM slave with programmable wait states and out-of-range error.
// Define APB_MEM_SLAVE_STRB_EN to enable byte-lane write strobes and the APB4 read-strobe error.
module apb_mem_slave_ws #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned MEM_DEPTH   = 32,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR
);

   localparam int unsigned NSTRB  = DATA_WIDTH / 8;
   localparam int unsigned LSB    = $clog2(NSTRB);
   localparam int unsigned IDX_W  = ADDR_WIDTH - LSB;
   localparam int unsigned MIDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int unsigned CNT_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

   localparam logic [IDX_W:0]   DEPTH_L = (IDX_W + 1)'(MEM_DEPTH);
   localparam logic [CNT_W-1:0] WAIT_L  = CNT_W'(WAIT_STATES);

   typedef enum logic [0:0] {IDLE, ACCESS} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [CNT_W-1:0]        cnt;
   logic                    err_q;
   logic                    setup_go;
   logic                    commit;
   logic [IDX_W-1:0]        idx;
   logic [MIDX_W-1:0]       midx;
   logic                    out_of_range;
   logic                    setup_err;
   logic [NSTRB-1:0]        lane_en;
   logic                    unused_bits;
   logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

   assign idx          = PADDR[ADDR_WIDTH-1:LSB];
   assign midx         = MIDX_W'(idx);
   assign out_of_range = ({1'b0, idx} >= DEPTH_L);
   assign unused_bits  = ^{PADDR, PSTRB};

`ifdef APB_MEM_SLAVE_STRB_EN
   assign setup_err = out_of_range | (!PWRITE & (|PSTRB));
   assign lane_en   = PSTRB;
`else
   assign setup_err = out_of_range;
   assign lane_en   = '1;
`endif

   // State register
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (PSEL && !PENABLE) state_nxt = ACCESS;
         ACCESS:  if (!PSEL || !PENABLE || PREADY) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs and strobes decoded from registered state only
   always_comb begin
      PREADY   = (state == ACCESS) && (cnt == WAIT_L);
      PSLVERR  = PREADY && err_q;
      setup_go = (state == IDLE) && PSEL && !PENABLE;
      commit   = PREADY && PSEL && PENABLE && PWRITE && !err_q;
   end

   generate
      if (WAIT_STATES == 0) begin : g_no_wait
         assign cnt = '0;
      end else begin : g_wait
         // Wait counter; stops at WAIT_STATES because PREADY then holds
         always_ff @(posedge PCLK or posedge PRESET) begin
            if (PRESET)                          cnt <= '0;
            else if (setup_go)                   cnt <= '0;
            else if (state == ACCESS && !PREADY) cnt <= cnt + CNT_W'(1);
         end
      end
   endgenerate

   // Error flag and read data captured at the setup edge
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         err_q  <= 1'b0;
         PRDATA <= '0;
      end else if (setup_go) begin
         err_q <= setup_err;
         if (!PWRITE) PRDATA <= setup_err ? '0 : mem[midx];
      end
   end

   // Storage array, intentionally not reset
   always_ff @(posedge PCLK) begin
      if (commit) begin
         for (int i = 0; i < int'(NSTRB); i++) begin
            if (lane_en[i]) mem[midx][8*i +: 8] <= PWDATA[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_apb_mem_slave_ws.sv
// Directed bench for apb_mem_slave_ws: one zero-wait and one three-wait instance on a shared bus.
module tb_apb_mem_slave_ws;

   logic        clk = 1'b0;
   logic        prst;
   logic        psel, penable, pwrite, tsel;
   logic [7:0]  paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic        psel0, psel1;
   logic [31:0] prdata0, prdata1, prdata_m;
   logic        pready0, pready1, pready_m;
   logic        pslverr0, pslverr1, pslverr_m;

   int n_checks = 0;
   int n_fail   = 0;

   assign psel0     = psel & ~tsel;
   assign psel1     = psel & tsel;
   assign prdata_m  = tsel ? prdata1  : prdata0;
   assign pready_m  = tsel ? pready1  : pready0;
   assign pslverr_m = tsel ? pslverr1 : pslverr0;

   always #5 clk = ~clk;

   apb_mem_slave_ws #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MEM_DEPTH(32), .WAIT_STATES(0)) u_ws0 (
      .PCLK(clk), .PRESET(prst), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
      .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0));

   apb_mem_slave_ws #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MEM_DEPTH(32), .WAIT_STATES(3)) u_ws3 (
      .PCLK(clk), .PRESET(prst), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
      .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One full transfer; entered and left at #1 after a rising edge
   task automatic apb_xfer(input logic which, input logic wr, input logic [7:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           output logic [31:0] rdata, output logic err,
                           output int waits, output logic stable);
      logic [31:0] first;
      tsel = which; psel = 1'b1; penable = 1'b0; pwrite = wr;
      paddr = addr; pwdata = wdata; pstrb = strb;
      @(posedge clk); #1 penable = 1'b1;
      waits = 0; stable = 1'b1;
      @(negedge clk); first = prdata_m;
      while (!pready_m && waits < 20) begin
         waits++;
         @(posedge clk); #1;
         @(negedge clk);
         if (prdata_m !== first) stable = 1'b0;
      end
      if (!pready_m) check("pready_timeout", 32'(pready_m), 32'd1);
      rdata = prdata_m; err = pslverr_m;
      @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   logic [31:0] rd, strb_exp;
   logic        er, st;
   int          ws;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      prst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tsel = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;
      #12;
      check("rst_prdata0", prdata0, 32'h0);
      check("rst_pready0", 32'(pready0), 32'd0);
      check("rst_pslverr0", 32'(pslverr0), 32'd0);
      check("rst_prdata1", prdata1, 32'h0);
      check("rst_pready1", 32'(pready1), 32'd0);
      check("rst_pslverr1", 32'(pslverr1), 32'd0);
      @(posedge clk); #1 prst = 1'b0;

      // Zero wait states: write then read back
      apb_xfer(1'b0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, rd, er, ws, st);
      check("ws0_wr_err", 32'(er), 32'd0);
      check("ws0_wr_waits", 32'(ws), 32'd0);
      apb_xfer(1'b0, 1'b0, 8'h04, 32'h0, 4'h0, rd, er, ws, st);
      check("ws0_rd_data", rd, 32'hDEADBEEF);
      check("ws0_rd_err", 32'(er), 32'd0);
      check("ws0_rd_waits", 32'(ws), 32'd0);

      // Three wait states
      apb_xfer(1'b1, 1'b1, 8'h08, 32'h12345678, 4'hF, rd, er, ws, st);
      check("ws3_wr_waits", 32'(ws), 32'd3);
      apb_xfer(1'b1, 1'b0, 8'h08, 32'h0, 4'h0, rd, er, ws, st);
      check("ws3_rd_waits", 32'(ws), 32'd3);
      check("ws3_rd_data", rd, 32'h12345678);
      check("ws3_rd_stable", 32'(st), 32'd1);
      check("ws3_rd_err", 32'(er), 32'd0);

      // Out-of-range accesses must not alias onto low words
      apb_xfer(1'b0, 1'b1, 8'h7C, 32'hCAFEF00D, 4'hF, rd, er, ws, st);
      apb_xfer(1'b0, 1'b1, 8'h00, 32'h0A0A0A0A, 4'hF, rd, er, ws, st);
      apb_xfer(1'b0, 1'b1, 8'h80, 32'hFFFFFFFF, 4'hF, rd, er, ws, st);
      check("oor_wr_err", 32'(er), 32'd1);
      apb_xfer(1'b0, 1'b0, 8'h80, 32'h0, 4'h0, rd, er, ws, st);
      check("oor_rd_data", rd, 32'h0);
      check("oor_rd_err", 32'(er), 32'd1);
      apb_xfer(1'b0, 1'b0, 8'h7C, 32'h0, 4'h0, rd, er, ws, st);
      check("oor_7c_intact", rd, 32'hCAFEF00D);
      apb_xfer(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, rd, er, ws, st);
      check("oor_00_intact", rd, 32'h0A0A0A0A);
      apb_xfer(1'b0, 1'b1, 8'h04, 32'h77777777, 4'hF, rd, er, ws, st);
      check("prdata_hold_wr", prdata0, 32'h0A0A0A0A);
      apb_xfer(1'b1, 1'b1, 8'hFC, 32'h1, 4'hF, rd, er, ws, st);
      check("oor_ws3_err", 32'(er), 32'd1);
      check("oor_ws3_waits", 32'(ws), 32'd3);

      // Byte-lane strobes
`ifdef APB_MEM_SLAVE_STRB_EN
      strb_exp = 32'h11BB33DD;
`else
      strb_exp = 32'hAABBCCDD;
`endif
      apb_xfer(1'b0, 1'b1, 8'h10, 32'h11223344, 4'hF, rd, er, ws, st);
      apb_xfer(1'b0, 1'b1, 8'h10, 32'hAABBCCDD, 4'b0101, rd, er, ws, st);
      check("strb_wr_err", 32'(er), 32'd0);
      apb_xfer(1'b0, 1'b0, 8'h13, 32'h0, 4'h0, rd, er, ws, st);
      check("strb_rd_data", rd, strb_exp);
      apb_xfer(1'b0, 1'b0, 8'h10, 32'h0, 4'b0001, rd, er, ws, st);
`ifdef APB_MEM_SLAVE_STRB_EN
      check("strb_rd_err", 32'(er), 32'd1);
      check("strb_rd_zero", rd, 32'h0);
`else
      check("strb_rd_err", 32'(er), 32'd0);
      check("strb_rd_data2", rd, strb_exp);
`endif

      // Abort a write in its second access cycle
      apb_xfer(1'b1, 1'b1, 8'h20, 32'h0BADF00D, 4'hF, rd, er, ws, st);
      apb_xfer(1'b1, 1'b0, 8'h08, 32'h0, 4'h0, rd, er, ws, st);
      tsel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 8'h20; pwdata = 32'h55555555; pstrb = 4'hF;
      @(posedge clk); #1 penable = 1'b1;
      @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      @(posedge clk); #1;
      check("abort_prdata_hold", prdata1, 32'h12345678);
      check("abort_pready", 32'(pready1), 32'd0);
      apb_xfer(1'b1, 1'b0, 8'h20, 32'h0, 4'h0, rd, er, ws, st);
      check("abort_mem_intact", rd, 32'h0BADF00D);
      check("abort_next_waits", 32'(ws), 32'd3);
      check("abort_next_err", 32'(er), 32'd0);

      // Reset pulsed in the final access cycle of a write
      apb_xfer(1'b1, 1'b1, 8'h24, 32'h13579BDF, 4'hF, rd, er, ws, st);
      apb_xfer(1'b1, 1'b0, 8'h20, 32'h0, 4'h0, rd, er, ws, st);
      tsel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 8'h24; pwdata = 32'h2468ACE0; pstrb = 4'hF;
      @(posedge clk); #1 penable = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_pre_pready", 32'(pready1), 32'd1);
      #1 prst = 1'b1;
      #1;
      check("midrst_prdata", prdata1, 32'h0);
      check("midrst_pready", 32'(pready1), 32'd0);
      check("midrst_pslverr", 32'(pslverr1), 32'd0);
      @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0; prst = 1'b0;
      apb_xfer(1'b1, 1'b0, 8'h24, 32'h0, 4'h0, rd, er, ws, st);
      check("midrst_not_written", rd, 32'h13579BDF);
      check("midrst_next_waits", 32'(ws), 32'd3);
      apb_xfer(1'b1, 1'b1, 8'h24, 32'h2468ACE0, 4'hF, rd, er, ws, st);
      apb_xfer(1'b1, 1'b0, 8'h24, 32'h0, 4'h0, rd, er, ws, st);
      check("post_rst_rw", rd, 32'h2468ACE0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
